// File: rtl/param_shift_seq_pkg.sv
// Shared definitions for the sequential shift register: operation codes,
// FSM state encoding and a mode classifier.
package shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_LOAD = 3'd1;
    localparam mode_t MODE_SHL  = 3'd2;
    localparam mode_t MODE_SHR  = 3'd3;
    localparam mode_t MODE_ROL  = 3'd4;
    localparam mode_t MODE_ROR  = 3'd5;
    localparam mode_t MODE_ASR  = 3'd6;
    localparam mode_t MODE_CLR  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift/rotate modes take `amount` steps; the others complete in one edge.
    function automatic logic is_step_mode(input mode_t m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/param_shift_seq_if.sv
// Controller-to-shifter bus: operation request, serial fills and result/status.
interface param_shift_seq_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    mode_t            mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] in_data;
    logic             ser_lsb;
    logic             ser_msb;
    logic [WIDTH-1:0] y;
    logic             so_msb;
    logic             so_lsb;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amount, in_data, ser_lsb, ser_msb,
        input  y, so_msb, so_lsb, busy, done
    );

    modport slave (
        input  start, mode, amount, in_data, ser_lsb, ser_msb,
        output y, so_msb, so_lsb, busy, done
    );
endinterface

// File: rtl/shift_step_unit.sv
// Combinational single-bit step for the shift/rotate modes; any other mode
// passes the current value through unchanged.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  mode_t            mode,
    input  logic             ser_lsb,
    input  logic             ser_msb,
    output logic [WIDTH-1:0] next
);
    always_comb begin
        // NOTE: default assigned first so every path drives `next` and no latch is inferred.
        next = cur;
        case (mode)
            MODE_SHL: next = {cur[WIDTH-2:0], ser_lsb};
            MODE_SHR: next = {ser_msb, cur[WIDTH-1:1]};
            MODE_ROL: next = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR: next = {cur[0], cur[WIDTH-1:1]};
            MODE_ASR: next = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  next = cur;
        endcase
    end
endmodule

// File: rtl/param_shift_seq.sv
// WIDTH-bit universal shift register executing multi-bit shifts one bit per
// clock under a start/busy/done handshake.
module param_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input logic              clk,
    input logic              rst,
    param_shift_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_next;

    // Step unit sees the latched mode only; live ser inputs give per-step fill.
    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .cur     (y_q),
        .mode    (mode_q),
        .ser_lsb (bus.ser_lsb),
        .ser_msb (bus.ser_msb),
        .next    (step_next)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.mode)
                        MODE_LOAD: begin y_d = bus.in_data; done_d = 1'b1; end
                        MODE_CLR:  begin y_d = '0;          done_d = 1'b1; end
                        MODE_HOLD: done_d = 1'b1;
                        default: begin
                            if (bus.amount == '0) begin
                                done_d = 1'b1;
                            end else begin
                                mode_d  = bus.mode;
                                cnt_d   = bus.amount;
                                state_d = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                y_d   = step_next;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset wins over any in-flight step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign bus.y      = y_q;
    assign bus.so_msb = y_q[WIDTH-1];
    assign bus.so_lsb = y_q[0];
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;

    // Only the state is relied on for the mode check; keep the classifier in use for readers.
    logic unused_mode_class;
    assign unused_mode_class = is_step_mode(mode_q);
endmodule

// File: doc/param_shift_seq.md
Name: param_shift_seq

Overview:
- Parametrised successor to the team's 8-bit universal shift register with parallel load.
- Generalised to WIDTH bits, with eight operation modes including rotate and arithmetic shift.
- Executes multi-bit shifts sequentially, one bit per clock, under a start/busy/done handshake.
- Sits between a controller FSM and datapath registers; serial ends are exposed for chaining.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input; holds values 0..WIDTH and above.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only while idle.
- mode  input  3  operation code, captured with start.
- amount  input  AMT_W  number of single-bit steps for shift/rotate modes, captured with start.
- in_data  input  WIDTH  parallel load value.
- ser_lsb  input  1  fill bit entering bit 0 on a logical left shift; sampled each shift cycle.
- ser_msb  input  1  fill bit entering bit WIDTH-1 on a logical right shift; sampled each shift cycle.
- y  output  WIDTH  register contents.
- so_msb  output  1  y[WIDTH-1], for chaining.
- so_lsb  output  1  y[0], for chaining.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge): y=0, busy=0, done=0, state IDLE, counter 0.
- Reset has priority over everything, including mid-operation; the partial result is discarded.
- Mode codes:
  - 0 HOLD
  - 1 LOAD (y<=in_data)
  - 2 SHL (y<={y[W-2:0],ser_lsb})
  - 3 SHR (y<={ser_msb,y[W-1:1]})
  - 4 ROL
  - 5 ROR
  - 6 ASR (y<={y[W-1],y[W-1:1]})
  - 7 CLR (y<=0)
- FSM has two states: IDLE and RUN.
- IDLE, start=0: y holds, done=0.
- IDLE, start=1 at edge t with mode HOLD, LOAD or CLR: the action is performed at edge t; done=1 in the following cycle; busy stays 0; amount is ignored.
- IDLE, start=1 at edge t with a shift/rotate mode and amount=0: y unchanged; done=1 in the following cycle; busy stays 0.
- IDLE, start=1 at edge t with a shift/rotate mode and amount=N≥1: mode and N are latched, the counter is loaded with N, state goes to RUN, busy=1.
- RUN: one single-bit step is applied at each of edges t+1..t+N, and the counter decrements each step.
- RUN, step where the counter reaches 0 (edge t+N): state returns to IDLE, busy=0, done=1 for exactly one cycle.
- Total latency: N+1 edges from start to the done cycle.
- start while busy: ignored. mode and amount are not re-sampled. A start held high on the done cycle is accepted as a new operation, since the FSM is already IDLE.
- Serial inputs: ser_lsb/ser_msb are sampled live at each step edge, not latched at start.
- amount > WIDTH: permitted; exactly N steps are performed. Rotates wrap modulo WIDTH; logical shifts fully flush with fill bits.
- done and busy are never high in the same cycle.
- No combinational path from inputs to y, busy or done. so_msb and so_lsb are wires from y.

Decomposition:
- Package shift_pkg holds:
  - localparams for the mode codes (MODE_HOLD..MODE_CLR);
  - FSM state encoding (ST_IDLE, ST_RUN).
- Sub-module shift_step_unit: purely combinational, single-bit step. Inputs: cur[WIDTH], mode, ser_lsb, ser_msb. Output: next[WIDTH].
- The top level holds the FSM, the counter and the y register, and instantiates one shift_step_unit.

Test Plan:
- Reset and load: rst for 2 cycles → y=0, busy=0, done=0. Then start, mode=LOAD, in_data=8'd58 → y=8'h3A after 1 edge, done pulse next cycle, busy never high.
- Logical shift: from 8'h3A, mode=SHL, amount=3, ser_lsb=0 → busy high for 3 cycles, then y=8'hD0 with a single done pulse. Intermediate values 8'h74, 8'hE8, 8'hD0.
- Rotate and arithmetic shift: ROR amount=4 on 8'h3A → 8'hA3. Load 8'h9C, then ASR amount=2 → 8'hE7.
- Fill, overlong count and ignored start: y=8'h00, SHR amount=9, ser_msb=1 → y=8'hFF after 9 steps. A start pulse with mode=CLR mid-run is ignored (y is not cleared).
- Reset mid-operation: SHL amount=5 from 8'h01, rst asserted after 2 steps → y=0, busy=0, no done pulse; the next start is accepted normally.
- Edge cases:
  - amount=0 with ROL → y unchanged, done after 1 edge, busy stays 0.
  - start held high across a done cycle → a back-to-back operation begins on the done edge.
